// File: rtl/data_packer_pkg.sv
// Shared constants, sizing helpers and the assembly-state type for the narrow-to-wide packer.
package data_packer_pkg;

  localparam int DEF_IN_WIDTH  = 64;
  localparam int DEF_OUT_WIDTH = 128;

  // Smallest bit count able to index 'value' distinct codes (minimum 1 bit).
  function automatic int C_LOG_2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits = bits + 1;
    return bits;
  endfunction

  function automatic int ceil_a_by_b(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  localparam int NUM_WORDS = ceil_a_by_b(DEF_OUT_WIDTH, DEF_IN_WIDTH);
  localparam int CNT_W     = C_LOG_2(NUM_WORDS + 1);

  // FILL: accepting narrow words. HOLD: a finished word is waiting for the output slot.
  typedef enum logic {
    ASM_FILL = 1'b0,
    ASM_HOLD = 1'b1
  } asm_state_e;

endpackage

// File: rtl/data_packer_if.sv
// Narrow-input / wide-output bus of data_packer; Flush and Packed_Cnt exist only with PACKER_FLUSH_EN.
interface data_packer_if
  import data_packer_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) ();

  localparam int CW = C_LOG_2(ceil_a_by_b(OUT_WIDTH, IN_WIDTH) + 1);

  // Both sides are valid/ready: a transfer happens on a rising clk edge where the
  // strobe and the ready are both 1; a strobe seen while ready is 0 is ignored and
  // not remembered. Packed_Dat holds steady while Packed_Val=1 and Packed_Rdy=0.
  logic                 Unpacked_EnWr;
  logic [IN_WIDTH-1:0]  Unpacked_DatWr;
  logic                 Unpacked_RdyWr;
  logic                 Packed_Val;
  logic [OUT_WIDTH-1:0] Packed_Dat;
  logic                 Packed_Rdy;
`ifdef PACKER_FLUSH_EN
  logic                 Flush;
  logic [CW-1:0]        Packed_Cnt;
`endif
  asm_state_e           dbg_state;
  logic [CW-1:0]        dbg_cnt;

  modport master (
    output Unpacked_EnWr, Unpacked_DatWr, Packed_Rdy,
`ifdef PACKER_FLUSH_EN
    output Flush,
    input  Packed_Cnt,
`endif
    input  Unpacked_RdyWr, Packed_Val, Packed_Dat, dbg_state, dbg_cnt
  );

  modport slave (
    input  Unpacked_EnWr, Unpacked_DatWr, Packed_Rdy,
`ifdef PACKER_FLUSH_EN
    input  Flush,
    output Packed_Cnt,
`endif
    output Unpacked_RdyWr, Packed_Val, Packed_Dat, dbg_state, dbg_cnt
  );

endinterface

// File: rtl/data_packer_out_reg.sv
// One-entry valid/ready output register of the packer (packer_out_reg); clr drops only the valid bit.
module data_packer_out_reg #(
  parameter int W = 128
`ifdef PACKER_FLUSH_EN
  , parameter int CW = 2
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [W-1:0]  load_dat,
`ifdef PACKER_FLUSH_EN
  input  logic [CW-1:0] load_cnt,
  output logic [CW-1:0] out_cnt,
`endif
  input  logic          out_rdy,
  output logic          out_val,
  output logic [W-1:0]  out_dat,
  output logic          slot_free
);

  // The slot can take a new word if it is empty or is being drained this cycle.
  assign slot_free = !out_val || out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val <= 1'b0;
      out_dat <= '0;
    end else if (clr) begin
      out_val <= 1'b0;
    end else if (load) begin
      out_val <= 1'b1;
      out_dat <= load_dat;
    end else if (out_rdy) begin
      out_val <= 1'b0;
    end
  end

`ifdef PACKER_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (!clr && load) begin
      out_cnt <= load_cnt;
    end
  end
`endif

endmodule

// File: rtl/data_packer.sv
// Narrow-to-wide packer: NUM_WORDS input words LSB-first into one registered wide word.
// Optional partial-word flush with a valid-word count is enabled by defining PACKER_FLUSH_EN.
module data_packer
  import data_packer_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  input logic          Reset,
  data_packer_if.slave bus
);

  localparam int N_WORDS = ceil_a_by_b(OUT_WIDTH, IN_WIDTH);
  localparam int CW      = C_LOG_2(N_WORDS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N_WORDS);

  if (((OUT_WIDTH % IN_WIDTH) != 0) || (OUT_WIDTH < IN_WIDTH)) begin : g_width_check
    $error("data_packer: OUT_WIDTH must be an integer multiple (>=1) of IN_WIDTH");
  end

  logic [CW-1:0]        asm_cnt, asm_cnt_nxt, cnt_wr;
  logic [OUT_WIDTH-1:0] asm_dat, asm_dat_nxt, shift_dat, cmp_dat, load_dat;
  logic                 rdy_wr, wr_acc, complete, load, slot_free;
  logic                 out_val;
  logic [OUT_WIDTH-1:0] out_dat;
`ifdef PACKER_FLUSH_EN
  logic [CW-1:0]        pend_cnt, pend_cnt_nxt, load_cnt, out_cnt;
`endif

  // New words enter at the top and walk down, so word 0 ends in the LSBs.
  if (N_WORDS == 1) begin : g_single
    assign shift_dat = bus.Unpacked_DatWr;
  end else begin : g_multi
    assign shift_dat = {bus.Unpacked_DatWr, asm_dat[OUT_WIDTH-1:IN_WIDTH]};
  end

  // asm_cnt == N_WORDS means a finished word is parked in asm_dat waiting for the slot.
  assign rdy_wr = (asm_cnt != CNT_FULL);
  assign wr_acc = bus.Unpacked_EnWr && rdy_wr;
  assign cnt_wr = asm_cnt + CW'(wr_acc);

  always_comb begin
    asm_cnt_nxt  = asm_cnt;
    asm_dat_nxt  = asm_dat;
    cmp_dat      = wr_acc ? shift_dat : asm_dat;
    complete     = 1'b0;
    load         = 1'b0;
    load_dat     = cmp_dat;
`ifdef PACKER_FLUSH_EN
    pend_cnt_nxt = pend_cnt;
    load_cnt     = cnt_wr;
`endif
    if (Reset) begin
      asm_cnt_nxt = '0;
    end else if (!rdy_wr) begin
      if (slot_free) begin
        load        = 1'b1;
        load_dat    = asm_dat;
        asm_cnt_nxt = '0;
`ifdef PACKER_FLUSH_EN
        load_cnt    = pend_cnt;
`endif
      end
    end else begin
      complete = (cnt_wr == CNT_FULL);
`ifdef PACKER_FLUSH_EN
      // A partial word is right-aligned so its valid words sit in the LSBs, zero above.
      if (bus.Flush && (cnt_wr != '0) && !complete) begin
        complete = 1'b1;
        cmp_dat  = cmp_dat >> ((N_WORDS - int'(cnt_wr)) * IN_WIDTH);
      end
`endif
      asm_dat_nxt = cmp_dat;
      load_dat    = cmp_dat;
      if (complete) begin
        if (slot_free) begin
          load        = 1'b1;
          asm_cnt_nxt = '0;
        end else begin
          asm_cnt_nxt  = CNT_FULL;
`ifdef PACKER_FLUSH_EN
          pend_cnt_nxt = cnt_wr;
`endif
        end
      end else begin
        asm_cnt_nxt = cnt_wr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_cnt <= '0;
      asm_dat <= '0;
    end else begin
      asm_cnt <= asm_cnt_nxt;
      asm_dat <= asm_dat_nxt;
    end
  end

`ifdef PACKER_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
    end else begin
      pend_cnt <= pend_cnt_nxt;
    end
  end
`endif

  data_packer_out_reg #(
    .W  (OUT_WIDTH)
`ifdef PACKER_FLUSH_EN
    , .CW (CW)
`endif
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (Reset),
    .load      (load),
    .load_dat  (load_dat),
`ifdef PACKER_FLUSH_EN
    .load_cnt  (load_cnt),
    .out_cnt   (out_cnt),
`endif
    .out_rdy   (bus.Packed_Rdy),
    .out_val   (out_val),
    .out_dat   (out_dat),
    .slot_free (slot_free)
  );

  assign bus.Unpacked_RdyWr = rdy_wr;
  assign bus.Packed_Val     = out_val;
  assign bus.Packed_Dat     = out_dat;
`ifdef PACKER_FLUSH_EN
  assign bus.Packed_Cnt     = out_cnt;
`endif
  assign bus.dbg_state      = rdy_wr ? ASM_FILL : ASM_HOLD;
  assign bus.dbg_cnt        = asm_cnt;

endmodule

// File: tb/tb_data_packer.sv
// Bench for data_packer: directed vectors, a queue-based model checked every cycle, and a transfer scoreboard.
module tb_data_packer;
  import data_packer_pkg::*;

  localparam int IW = 64;
  localparam int OW = 128;
  localparam int NW = OW / IW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic sync_clr;
  always #5 clk = ~clk;

  data_packer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  data_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Reset (sync_clr),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- model + scoreboard ----------------
  logic [IW-1:0] part_q[$];
  logic [OW-1:0] exp_q[$];
  bit            wait_v;
  logic [OW-1:0] wait_dat;
  int            wait_cnt;
  bit            m_val;
  logic [OW-1:0] m_dat;
  int            m_cnt;

  function automatic logic [OW-1:0] pack_words();
    logic [OW-1:0] w;
    w = '0;
    foreach (part_q[i]) w[i*IW +: IW] = part_q[i];
    return w;
  endfunction

  task automatic load_word(input logic [OW-1:0] w, input int c);
    m_val = 1'b1;
    m_dat = w;
    m_cnt = c;
    exp_q.push_back(w);
  endtask

  // Advances the model across the coming rising edge using the inputs now on the bus.
  task automatic model_step();
    bit            free, drained, done;
    logic [OW-1:0] w;
    int            c;
    free    = !m_val || bus.Packed_Rdy;
    drained = m_val && bus.Packed_Rdy;
    if (sync_clr) begin
      if (m_val && !bus.Packed_Rdy) void'(exp_q.pop_back());
      part_q.delete();
      wait_v = 1'b0;
      m_val  = 1'b0;
    end else if (wait_v) begin
      if (free) begin
        load_word(wait_dat, wait_cnt);
        wait_v = 1'b0;
      end
    end else begin
      if (bus.Unpacked_EnWr) part_q.push_back(bus.Unpacked_DatWr);
      done = (part_q.size() == NW);
`ifdef PACKER_FLUSH_EN
      if (bus.Flush && part_q.size() > 0) done = 1'b1;
`endif
      if (done) begin
        w = pack_words();
        c = part_q.size();
        part_q.delete();
        if (free) load_word(w, c);
        else begin
          wait_v   = 1'b1;
          wait_dat = w;
          wait_cnt = c;
        end
      end else if (drained) begin
        m_val = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      part_q.delete();
      exp_q.delete();
      wait_v = 1'b0;
      m_val  = 1'b0;
      m_dat  = '0;
      m_cnt  = 0;
    end else begin
      if (chk_en) begin
        check("cyc_rdywr", bus.Unpacked_RdyWr, !wait_v);
        check("cyc_val", bus.Packed_Val, m_val);
        if (m_val) check("cyc_dat", bus.Packed_Dat, m_dat);
`ifdef PACKER_FLUSH_EN
        if (m_val) check("cyc_cnt", bus.Packed_Cnt, m_cnt);
`endif
        if (bus.Packed_Val && bus.Packed_Rdy) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL xfer_dat: got %0h expected no transfer", bus.Packed_Dat);
          end else begin
            check("xfer_dat", bus.Packed_Dat, exp_q.pop_front());
          end
        end
      end
      model_step();
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic en, input logic [IW-1:0] dat, input logic rdy,
                       input logic clr, input logic fl);
    bus.Unpacked_EnWr  = en;
    bus.Unpacked_DatWr = dat;
    bus.Packed_Rdy     = rdy;
    sync_clr           = clr;
`ifdef PACKER_FLUSH_EN
    bus.Flush          = fl;
`else
    if (fl) $display("note: flush requested but not built in");
`endif
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n              = 1'b0;
    sync_clr           = 1'b0;
    bus.Unpacked_EnWr  = 1'b0;
    bus.Unpacked_DatWr = '0;
    bus.Packed_Rdy     = 1'b0;
`ifdef PACKER_FLUSH_EN
    bus.Flush          = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_val", bus.Packed_Val, 1'b0);
    check("rst_dat", bus.Packed_Dat, '0);
    check("rst_rdywr", bus.Unpacked_RdyWr, 1'b1);
`ifdef PACKER_FLUSH_EN
    check("rst_cnt", bus.Packed_Cnt, '0);
`endif
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 1: two words with Rdy=1 -> one wide word, valid for exactly one cycle
    drive(1'b1, 64'hA, 1'b1, 1'b0, 1'b0);
    check("t1_val_early", bus.Packed_Val, 1'b0);
    drive(1'b1, 64'hB, 1'b1, 1'b0, 1'b0);
    check("t1_val", bus.Packed_Val, 1'b1);
    check("t1_dat", bus.Packed_Dat, {64'hB, 64'hA});
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("t1_val_low", bus.Packed_Val, 1'b0);

    // 2: continuous stream, one wide word every second cycle, input never stalls
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'h100 + 64'(i), 1'b1, 1'b0, 1'b0);
      check("t2_rdywr", bus.Unpacked_RdyWr, 1'b1);
      check("t2_val", bus.Packed_Val, (i % 2) == 1);
    end
    check("t2_dat", bus.Packed_Dat, {64'h107, 64'h106});
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // 3: downstream stalled -> second word parked, input blocked, extra write dropped
    drive(1'b1, 64'h20, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h21, 1'b0, 1'b0, 1'b0);
    check("t3_first", bus.Packed_Dat, {64'h21, 64'h20});
    drive(1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h23, 1'b0, 1'b0, 1'b0);
    check("t3_rdywr", bus.Unpacked_RdyWr, 1'b0);
    check("t3_cnt", bus.dbg_cnt, 2);
    check("t3_state", bus.dbg_state, ASM_HOLD);
    drive(1'b1, 64'h24, 1'b0, 1'b0, 1'b0);
    check("t3_ignored_rdywr", bus.Unpacked_RdyWr, 1'b0);
    check("t3_hold_dat", bus.Packed_Dat, {64'h21, 64'h20});
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("t3_next_val", bus.Packed_Val, 1'b1);
    check("t3_next_dat", bus.Packed_Dat, {64'h23, 64'h22});
    check("t3_rdy_back", bus.Unpacked_RdyWr, 1'b1);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("t3_drained", bus.Packed_Val, 1'b0);
    drive(1'b1, 64'h25, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h26, 1'b1, 1'b0, 1'b0);
    check("t3_clean", bus.Packed_Dat, {64'h26, 64'h25});
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // 4: synchronous clear mid-word wins over a same-cycle write
    drive(1'b1, 64'h30, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h31, 1'b1, 1'b1, 1'b0);
    check("t4_cnt", bus.dbg_cnt, 0);
    check("t4_val", bus.Packed_Val, 1'b0);
    drive(1'b1, 64'h32, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h33, 1'b1, 1'b0, 1'b0);
    check("t4_dat", bus.Packed_Dat, {64'h33, 64'h32});
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // 5: asynchronous reset while a word is presented
    drive(1'b1, 64'h40, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h41, 1'b0, 1'b0, 1'b0);
    check("t5_val_pre", bus.Packed_Val, 1'b1);
    bus.Unpacked_EnWr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_val", bus.Packed_Val, 1'b0);
    check("t5_dat", bus.Packed_Dat, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("t5_rdywr", bus.Unpacked_RdyWr, 1'b1);

`ifdef PACKER_FLUSH_EN
    // 6: flush of partial words, idle flush, same-cycle write+flush, flush while slot busy
    drive(1'b1, 64'h5, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    check("t6_val", bus.Packed_Val, 1'b1);
    check("t6_dat", bus.Packed_Dat, 128'h5);
    check("t6_cnt", bus.Packed_Cnt, 1);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    check("t6_idle", bus.Packed_Val, 1'b0);
    drive(1'b1, 64'h7, 1'b1, 1'b0, 1'b1);
    check("t6_same_dat", bus.Packed_Dat, 128'h7);
    check("t6_same_cnt", bus.Packed_Cnt, 1);
    drive(1'b1, 64'h8, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h9, 1'b1, 1'b0, 1'b0);
    check("t6_full_cnt", bus.Packed_Cnt, NW);
    drive(1'b1, 64'hC, 1'b0, 1'b0, 1'b1);
    check("t6_wait_rdywr", bus.Unpacked_RdyWr, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("t6_wait_dat", bus.Packed_Dat, 128'hC);
    check("t6_wait_cnt", bus.Packed_Cnt, 1);
`endif

    repeat (3) drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    check("sb_empty", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
